// File: rtl/mult_job_arbiter.sv
// Round-robin arbiter that time-shares one multiply/popcount engine among NREQ
// requesters. It launches one job at a time, routes results back, and aborts hung jobs.
module mult_job_arbiter #(
  parameter int NREQ    = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      req,
  input  logic [24*NREQ-1:0]   req_a1,
  input  logic [24*NREQ-1:0]   req_a2,
  output logic [NREQ-1:0]      req_ack,
  output logic [NREQ-1:0]      rsp_valid,
  output logic [31:0]          rsp_product,
  output logic                 rsp_ok,
  output logic [5:0]           rsp_ones,
  output logic                 rsp_timeout,
  output logic                 eng_start,
  output logic                 eng_abort,
  output logic [23:0]          eng_a1,
  output logic [23:0]          eng_a2,
  input  logic                 eng_done,
  input  logic [31:0]          eng_product,
  input  logic                 eng_ok,
  input  logic [5:0]           eng_ones,
  output logic                 busy,
  output logic [15:0]          job_count,
  output logic [1:0]           dbg_state
);
  // Handshake: req is a level held with its operands until the one-cycle req_ack;
  // rsp_valid is a one-cycle pulse and rsp_* stay stable until the next response.
  localparam int IW  = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int WDW = $clog2(TIMEOUT);

  typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

  state_t           state_q, state_d;
  logic [IW-1:0]    last_q, last_d, grant_q, grant_d, pick_idx;
  logic             pick_valid;
  logic [23:0]      a1_q, a1_d, a2_q, a2_d;
  logic [WDW-1:0]   wd_q, wd_d;
  logic [31:0]      prod_q, prod_d;
  logic             ok_q, ok_d, to_q, to_d;
  logic [5:0]       ones_q, ones_d;
  logic [15:0]      job_q, job_d;

  // First requester after the previous winner, wrapping modulo NREQ.
  always_comb begin
    pick_valid = 1'b0;
    pick_idx   = '0;
    for (int i = 1; i <= NREQ; i++) begin
      if (!pick_valid && req[(int'(last_q) + i) % NREQ]) begin
        pick_valid = 1'b1;
        pick_idx   = IW'((int'(last_q) + i) % NREQ);
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    last_d    = last_q;
    grant_d   = grant_q;
    a1_d      = a1_q;
    a2_d      = a2_q;
    wd_d      = wd_q;
    prod_d    = prod_q;
    ok_d      = ok_q;
    ones_d    = ones_q;
    to_d      = to_q;
    job_d     = job_q;
    req_ack   = '0;
    rsp_valid = '0;
    eng_start = 1'b0;
    eng_abort = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (pick_valid) begin
          grant_d = pick_idx;
          last_d  = pick_idx;
          a1_d    = req_a1[24*pick_idx +: 24];
          a2_d    = req_a2[24*pick_idx +: 24];
          state_d = S_ISSUE;
        end
      end
      S_ISSUE: begin
        req_ack[grant_q] = 1'b1;
        eng_start        = 1'b1;
        wd_d             = '0;
        state_d          = S_WAIT;
      end
      S_WAIT: begin
        // A completion in the expiry cycle still counts as success.
        if (eng_done) begin
          prod_d  = eng_product;
          ok_d    = eng_ok;
          ones_d  = eng_ones;
          to_d    = 1'b0;
          state_d = S_RESP;
        end else if (wd_q == WDW'(TIMEOUT - 1)) begin
          eng_abort = 1'b1;
          prod_d    = '0;
          ok_d      = 1'b0;
          ones_d    = '0;
          to_d      = 1'b1;
          state_d   = S_RESP;
        end else begin
          wd_d = wd_q + 1'b1;
        end
      end
      S_RESP: begin
        rsp_valid[grant_q] = 1'b1;
        if (!to_q) job_d = job_q + 16'd1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      last_q  <= IW'(NREQ - 1);
      grant_q <= '0;
      a1_q    <= '0;
      a2_q    <= '0;
      wd_q    <= '0;
      prod_q  <= '0;
      ok_q    <= 1'b0;
      ones_q  <= '0;
      to_q    <= 1'b0;
      job_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      grant_q <= grant_d;
      a1_q    <= a1_d;
      a2_q    <= a2_d;
      wd_q    <= wd_d;
      prod_q  <= prod_d;
      ok_q    <= ok_d;
      ones_q  <= ones_d;
      to_q    <= to_d;
      job_q   <= job_d;
    end
  end

  assign eng_a1      = a1_q;
  assign eng_a2      = a2_q;
  assign rsp_product = prod_q;
  assign rsp_ok      = ok_q;
  assign rsp_ones    = ones_q;
  assign rsp_timeout = to_q;
  assign busy        = (state_q != S_IDLE);
  assign job_count   = job_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_mult_job_arbiter.sv
// Bench for mult_job_arbiter: behavioural engine, requester driver tasks and an
// expected-response queue checked as responses come back.
module tb_mult_job_arbiter;
  localparam int NREQ    = 4;
  localparam int TIMEOUT = 64;
  localparam int W       = 43; // {idx[2:0], timeout, ones[5:0], ok, product[31:0]}

  logic                clk = 1'b0;
  logic                reset;
  logic [NREQ-1:0]     req;
  logic [24*NREQ-1:0]  req_a1, req_a2;
  logic [NREQ-1:0]     req_ack, rsp_valid;
  logic [31:0]         rsp_product;
  logic                rsp_ok, rsp_timeout, eng_start, eng_abort, busy;
  logic [5:0]          rsp_ones;
  logic [23:0]         eng_a1, eng_a2;
  logic                eng_done = 1'b0;
  logic [31:0]         eng_product = '0;
  logic                eng_ok = 1'b0;
  logic [5:0]          eng_ones = '0;
  logic [15:0]         job_count;
  logic [1:0]          dbg_state;

  logic [W-1:0] exp_q[$];
  int           ack_q[$];
  int           cmp_cnt = 0;
  int           err_cnt = 0;
  int           eng_lat = 1;
  bit           eng_mute = 1'b0;
  int           cyc = 0, abort_cnt = 0, abort_cyc = 0, start_cyc = 0, rsp_cnt = 0;
  logic [47:0]  eng_p;

  always #5 clk = ~clk;

  mult_job_arbiter #(.NREQ(NREQ), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset), .req(req), .req_a1(req_a1), .req_a2(req_a2),
    .req_ack(req_ack), .rsp_valid(rsp_valid), .rsp_product(rsp_product),
    .rsp_ok(rsp_ok), .rsp_ones(rsp_ones), .rsp_timeout(rsp_timeout),
    .eng_start(eng_start), .eng_abort(eng_abort), .eng_a1(eng_a1), .eng_a2(eng_a2),
    .eng_done(eng_done), .eng_product(eng_product), .eng_ok(eng_ok),
    .eng_ones(eng_ones), .busy(busy), .job_count(job_count), .dbg_state(dbg_state)
  );

  // Engine: done pulse eng_lat cycles after the start cycle, results valid with it.
  always begin
    @(posedge clk);
    #1;
    eng_done = 1'b0;
    if (eng_start && !eng_mute) begin
      eng_p = eng_a1 * eng_a2;
      repeat (eng_lat) @(posedge clk);
      #1;
      eng_done    = 1'b1;
      eng_product = eng_p[31:0];
      eng_ok      = (eng_p[47:32] == 16'd0);
      eng_ones    = 6'($countones(eng_p[31:0]));
    end
  end

  always @(negedge clk) begin
    cyc <= cyc + 1;
    if (eng_abort) begin
      abort_cnt <= abort_cnt + 1;
      abort_cyc <= cyc;
    end
    if (eng_start) start_cyc <= cyc;
    if (|rsp_valid) rsp_cnt <= rsp_cnt + 1;
    for (int i = 0; i < NREQ; i++) if (req_ack[i]) ack_q.push_back(i);
  end

  function automatic logic [W-1:0] mk_exp(input int idx, input logic [23:0] a1,
                                          input logic [23:0] a2, input logic to);
    logic [47:0] p;
    p = a1 * a2;
    if (to) return {3'(idx), 1'b1, 6'd0, 1'b0, 32'd0};
    return {3'(idx), 1'b0, 6'($countones(p[31:0])), (p[47:32] == 16'd0), p[31:0]};
  endfunction

  // Raise req[idx] with operands, wait (bounded) for its ack, then drop req.
  task automatic issue(input int idx, input logic [23:0] a1, input logic [23:0] a2,
                       output int lat, output logic [NREQ-1:0] ack_seen);
    req_a1[24*idx +: 24] = a1;
    req_a2[24*idx +: 24] = a2;
    req[idx] = 1'b1;
    lat = 0;
    ack_seen = '0;
    do begin
      @(negedge clk);
      lat++;
      ack_seen = req_ack;
    end while (!req_ack[idx] && lat < 200);
    req[idx] = 1'b0;
  endtask

  task automatic wait_rsp(output logic got, output int n, output logic [NREQ-1:0] rv,
                          output logic [39:0] obs);
    got = 1'b0; n = 0; rv = '0; obs = '0;
    while (!got && n < 200) begin
      @(negedge clk);
      n++;
      if (|rsp_valid) begin
        got = 1'b1;
        rv  = rsp_valid;
        obs = {rsp_timeout, rsp_ones, rsp_ok, rsp_product};
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if ({req_ack, rsp_valid, eng_start, eng_abort, busy, dbg_state} !== '0) begin
      err_cnt++;
      $display("FAIL reset_ctrl: got ack=%b rv=%b st=%b ab=%b busy=%b state=%0d, need all 0",
               req_ack, rsp_valid, eng_start, eng_abort, busy, dbg_state);
    end
    cmp_cnt++;
    if ({rsp_product, rsp_ok, rsp_ones, rsp_timeout, eng_a1, eng_a2, job_count} !== '0) begin
      err_cnt++;
      $display("FAIL reset_data: got prod=%h ok=%b ones=%0d to=%b a1=%h a2=%h jc=%0d, need 0",
               rsp_product, rsp_ok, rsp_ones, rsp_timeout, eng_a1, eng_a2, job_count);
    end
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single();
    int lat, n;
    logic got;
    logic [NREQ-1:0] ack, rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    eng_lat = 2;
    exp_q.push_back({3'd0, 1'b0, 6'd4, 1'b1, 32'h0000000F});
    issue(0, 24'h000003, 24'h000005, lat, ack);
    cmp_cnt++;
    if (lat !== 1 || ack !== 4'b0001 || eng_start !== 1'b1) begin
      err_cnt++;
      $display("FAIL single_ack: got lat=%0d ack=%b start=%b, need 1/0001/1", lat, ack, eng_start);
    end
    cmp_cnt++;
    if ({eng_a1, eng_a2} !== {24'h000003, 24'h000005}) begin
      err_cnt++;
      $display("FAIL single_operands: got %h/%h, need 000003/000005", eng_a1, eng_a2);
    end
    wait_rsp(got, n, rv, obs);
    e = exp_q.pop_front();
    cmp_cnt++;
    if (got !== 1'b1 || n !== 3 || rv !== (4'b0001 << e[42:40])) begin
      err_cnt++;
      $display("FAIL single_rsp_timing: got seen=%b n=%0d rv=%b, need 1/3/%b",
               got, n, rv, 4'b0001 << e[42:40]);
    end
    cmp_cnt++;
    if (obs !== e[39:0]) begin
      err_cnt++;
      $display("FAIL single_rsp_data: got %h, need %h", obs, e[39:0]);
    end
    @(negedge clk);
    cmp_cnt++;
    if (job_count !== 16'd1 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL single_count: got jc=%0d busy=%b, need 1/0", job_count, busy);
    end
  endtask

  task automatic test_round_robin();
    logic [23:0] a1s [NREQ];
    logic [23:0] a2s [NREQ];
    logic got;
    int n, g;
    logic [NREQ-1:0] rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    a1s = '{24'h000007, 24'h123456, 24'h00FFFF, 24'hFFFFFF};
    a2s = '{24'h000009, 24'h000010, 24'h00FFFF, 24'h001000};
    eng_lat = 1;
    ack_q.delete();
    // Previous winner was requester 0, so rotation starts at 1.
    for (int j = 0; j < 8; j++) begin
      g = (1 + j) % NREQ;
      exp_q.push_back(mk_exp(g, a1s[g], a2s[g], 1'b0));
    end
    for (int i = 0; i < NREQ; i++) begin
      req_a1[24*i +: 24] = a1s[i];
      req_a2[24*i +: 24] = a2s[i];
    end
    req = '1;
    for (int j = 0; j < 8; j++) begin
      wait_rsp(got, n, rv, obs);
      if (j == 7) req = '0;
      e = exp_q.pop_front();
      cmp_cnt++;
      if (got !== 1'b1 || rv !== (4'b0001 << e[42:40]) || obs !== e[39:0]) begin
        err_cnt++;
        $display("FAIL rr_rsp%0d: got seen=%b rv=%b data=%h, need rv=%b data=%h",
                 j, got, rv, obs, 4'b0001 << e[42:40], e[39:0]);
      end
    end
    @(negedge clk);
    for (int j = 0; j < 8; j++) begin
      cmp_cnt++;
      if (ack_q.size() <= j || ack_q[j] !== (1 + j) % NREQ) begin
        err_cnt++;
        $display("FAIL rr_grant%0d: got %0d (of %0d acks), need %0d", j,
                 (ack_q.size() > j) ? ack_q[j] : -1, ack_q.size(), (1 + j) % NREQ);
      end
    end
    cmp_cnt++;
    if (job_count !== 16'd9 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL rr_count: got jc=%0d busy=%b, need 9/0", job_count, busy);
    end
  endtask

  task automatic test_timeout();
    int lat, n, ab0;
    logic got;
    logic [NREQ-1:0] ack, rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    logic [15:0] jc0;
    eng_mute = 1'b1;
    ab0 = abort_cnt;
    jc0 = job_count;
    exp_q.push_back(mk_exp(1, 24'h000002, 24'h000003, 1'b1));
    issue(1, 24'h000002, 24'h000003, lat, ack);
    wait_rsp(got, n, rv, obs);
    e = exp_q.pop_front();
    cmp_cnt++;
    if (got !== 1'b1 || n !== TIMEOUT + 1 || rv !== (4'b0001 << e[42:40]) || obs !== e[39:0]) begin
      err_cnt++;
      $display("FAIL timeout_rsp: got seen=%b n=%0d rv=%b data=%h, need n=%0d rv=%b data=%h",
               got, n, rv, obs, TIMEOUT + 1, 4'b0001 << e[42:40], e[39:0]);
    end
    cmp_cnt++;
    if (abort_cnt !== ab0 + 1 || abort_cyc - start_cyc !== TIMEOUT) begin
      err_cnt++;
      $display("FAIL timeout_abort: got %0d pulses at +%0d, need 1 at +%0d",
               abort_cnt - ab0, abort_cyc - start_cyc, TIMEOUT);
    end
    @(negedge clk);
    cmp_cnt++;
    if (job_count !== jc0 || busy !== 1'b0) begin
      err_cnt++;
      $display("FAIL timeout_after: got jc=%0d busy=%b, need %0d/0", job_count, busy, jc0);
    end
    eng_mute = 1'b0;
  endtask

  task automatic test_coincide();
    int lat, n, ab0;
    logic got;
    logic [NREQ-1:0] ack, rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    logic [15:0] jc0;
    eng_lat = TIMEOUT;
    ab0 = abort_cnt;
    jc0 = job_count;
    exp_q.push_back(mk_exp(2, 24'h000100, 24'h000100, 1'b0));
    issue(2, 24'h000100, 24'h000100, lat, ack);
    wait_rsp(got, n, rv, obs);
    e = exp_q.pop_front();
    cmp_cnt++;
    if (got !== 1'b1 || n !== TIMEOUT + 1 || rv !== (4'b0001 << e[42:40]) || obs !== e[39:0]) begin
      err_cnt++;
      $display("FAIL coincide_rsp: got seen=%b n=%0d rv=%b data=%h, need n=%0d rv=%b data=%h",
               got, n, rv, obs, TIMEOUT + 1, 4'b0001 << e[42:40], e[39:0]);
    end
    @(negedge clk);
    cmp_cnt++;
    if (abort_cnt !== ab0 || job_count !== jc0 + 16'd1) begin
      err_cnt++;
      $display("FAIL coincide_after: got aborts=%0d jc=%0d, need 0/%0d",
               abort_cnt - ab0, job_count, jc0 + 16'd1);
    end
    eng_lat = 1;
  endtask

  task automatic test_reset_mid_job();
    int lat, n, ab0, rc0;
    logic got;
    logic [NREQ-1:0] ack, rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    eng_mute = 1'b1;
    issue(2, 24'h000011, 24'h000022, lat, ack);
    repeat (5) @(negedge clk);
    cmp_cnt++;
    if (dbg_state !== 2'd2) begin
      err_cnt++;
      $display("FAIL midreset_wait: got state %0d, need 2", dbg_state);
    end
    ab0 = abort_cnt;
    rc0 = rsp_cnt;
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    cmp_cnt++;
    if (busy !== 1'b0 || job_count !== 16'd0 || rsp_valid !== '0) begin
      err_cnt++;
      $display("FAIL midreset_state: got busy=%b jc=%0d rv=%b, need 0/0/0", busy, job_count, rsp_valid);
    end
    repeat (3) @(negedge clk);
    cmp_cnt++;
    if (rsp_cnt !== rc0 || abort_cnt !== ab0) begin
      err_cnt++;
      $display("FAIL midreset_pulses: got rsp=%0d abort=%0d, need 0/0", rsp_cnt - rc0, abort_cnt - ab0);
    end
    eng_mute = 1'b0;
    req_a1[48 +: 24] = 24'h000021;
    req_a2[48 +: 24] = 24'h000002;
    req[2] = 1'b1;
    exp_q.push_back(mk_exp(0, 24'h000004, 24'h000004, 1'b0));
    exp_q.push_back(mk_exp(2, 24'h000021, 24'h000002, 1'b0));
    issue(0, 24'h000004, 24'h000004, lat, ack);
    cmp_cnt++;
    if (ack !== 4'b0001) begin
      err_cnt++;
      $display("FAIL midreset_grant: got ack=%b, need 0001", ack);
    end
    for (int j = 0; j < 2; j++) begin
      wait_rsp(got, n, rv, obs);
      if (j == 1) req[2] = 1'b0;
      e = exp_q.pop_front();
      cmp_cnt++;
      if (got !== 1'b1 || rv !== (4'b0001 << e[42:40]) || obs !== e[39:0]) begin
        err_cnt++;
        $display("FAIL midreset_rsp%0d: got seen=%b rv=%b data=%h, need rv=%b data=%h",
                 j, got, rv, obs, 4'b0001 << e[42:40], e[39:0]);
      end
    end
    @(negedge clk);
    cmp_cnt++;
    if (job_count !== 16'd2) begin
      err_cnt++;
      $display("FAIL midreset_count: got %0d, need 2", job_count);
    end
  endtask

  task automatic test_count_wrap();
    int lat, n;
    logic got;
    logic [NREQ-1:0] ack, rv;
    logic [39:0] obs;
    logic [W-1:0] e;
    force dut.job_q = 16'hFFFF;
    repeat (2) @(negedge clk);
    release dut.job_q;
    @(negedge clk);
    cmp_cnt++;
    if (job_count !== 16'hFFFF) begin
      err_cnt++;
      $display("FAIL wrap_preload: got %h, need ffff", job_count);
    end
    exp_q.push_back(mk_exp(3, 24'hFFFFFF, 24'hFFFFFF, 1'b0));
    issue(3, 24'hFFFFFF, 24'hFFFFFF, lat, ack);
    wait_rsp(got, n, rv, obs);
    e = exp_q.pop_front();
    cmp_cnt++;
    if (got !== 1'b1 || rv !== (4'b0001 << e[42:40]) || obs !== e[39:0]) begin
      err_cnt++;
      $display("FAIL wrap_rsp: got seen=%b rv=%b data=%h, need rv=%b data=%h",
               got, rv, obs, 4'b0001 << e[42:40], e[39:0]);
    end
    @(negedge clk);
    cmp_cnt++;
    if (job_count !== 16'h0000) begin
      err_cnt++;
      $display("FAIL wrap_count: got %h, need 0000", job_count);
    end
  endtask

  initial begin
    reset  = 1'b1;
    req    = '0;
    req_a1 = '0;
    req_a2 = '0;
    test_reset();
    test_single();
    test_round_robin();
    test_timeout();
    test_coincide();
    test_reset_mid_job();
    test_count_wrap();
    cmp_cnt++;
    if (exp_q.size() != 0) begin
      err_cnt++;
      $display("FAIL scoreboard_drain: got %0d leftover, need 0", exp_q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end

endmodule
